// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand/opcode request side and result side.
// master = producer/consumer environment, slave = the ALU.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   // valid/ready: a transfer happens at a rising clock edge where both are 1;
   // the source holds its payload until that edge, the sink may raise ready
   // independently of valid.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] R;
   logic [3:0]       flags;

   modport master (
      output in_valid, A, B, sel, out_ready,
      input  in_ready, out_valid, R, flags
   );

   modport slave (
      input  in_valid, A, B, sel, out_ready,
      output in_ready, out_valid, R, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with registered result and {V,N,Z,C} flags; MUL runs as an
// iterative shift-add over WIDTH cycles, all other ops complete at the accept edge.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus,
   output logic [1:0] dbg_state
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     r_q, r_d;
   logic [3:0]           flags_q, flags_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [WIDTH:0]       sum_w;
   logic [WIDTH:0]       diff_w;
   logic [WIDTH-1:0]     alu_r;
   logic                 alu_c;
   logic                 alu_v;
   logic [2*WIDTH-1:0]   acc_step;
   logic                 in_ready;
   logic                 out_valid;
   logic                 accept;

   // Single-cycle datapath, evaluated on the live request operands.
   always_comb begin
      sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
      diff_w = {1'b0, bus.A} - {1'b0, bus.B};
      alu_r  = '0;
      alu_c  = 1'b0;
      alu_v  = 1'b0;
      case (bus.sel)
         OP_ADD: begin
            alu_r = sum_w[WIDTH-1:0];
            alu_c = sum_w[WIDTH];
            alu_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = diff_w[WIDTH-1:0];
            alu_c = diff_w[WIDTH];
            alu_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND: alu_r = bus.A & bus.B;
         OP_OR:  alu_r = bus.A | bus.B;
         OP_XOR: alu_r = bus.A ^ bus.B;
         OP_ROL: begin
            alu_r = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            alu_c = bus.A[WIDTH-1];
         end
         OP_ROR: begin
            alu_r = {bus.A[0], bus.A[WIDTH-1:1]};
            alu_c = bus.A[0];
         end
         default: alu_r = '0;
      endcase
   end

   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      flags_d   = flags_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;

      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // The last partial product is folded into the result load.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_DONE;
               r_d     = acc_step[WIDTH-1:0];
               flags_d = {1'b0, acc_step[WIDTH-1], (acc_step[WIDTH-1:0] == '0),
                          (|acc_step[2*WIDTH-1:WIDTH])};
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
            if (bus.out_ready && !bus.in_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      accept = bus.in_valid && in_ready;
      if (accept) begin
         if (bus.sel == OP_MUL) begin
            state_d  = ST_BUSY;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            cnt_d    = '0;
         end else begin
            state_d = ST_DONE;
            r_d     = alu_r;
            flags_d = {alu_v, alu_r[WIDTH-1], (alu_r == '0), alu_c};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         r_q      <= '0;
         flags_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         flags_q  <= flags_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.R         = r_q;
   assign bus.flags     = flags_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed + randomized bench for alu_pipe at WIDTH=8 against an arithmetic
// reference model of the opcode rules.
module tb_alu_pipe;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;
   int         n_tests = 0;
   int         n_fail = 0;

   logic [W+3:0] prev_rf = '0;
   logic [W+3:0] exp_q[$];

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns {V,N,Z,C,R} computed with plain integer arithmetic.
   function automatic logic [W+3:0] ref_op(input int a, input int b, input int op);
      int m, half, full, res, sa, sb, sr;
      logic c, v, n, z;
      logic [W-1:0] r;
      m = 1 << W;
      half = m / 2;
      c = 1'b0;
      v = 1'b0;
      sa = (a >= half) ? a - m : a;
      sb = (b >= half) ? b - m : b;
      case (op)
         0: begin full = a + b; c = (full >= m); sr = sa + sb; v = (sr >= half) || (sr < -half); end
         1: begin full = a - b; c = (a < b); sr = sa - sb; v = (sr >= half) || (sr < -half); end
         2: full = a & b;
         3: full = a | b;
         4: begin full = a * 2 + a / half; c = (a >= half); end
         5: begin full = a / 2 + (a % 2) * half; c = (a % 2 == 1); end
         6: full = a ^ b;
         default: begin full = a * b; c = (full >= m); end
      endcase
      res = ((full % m) + m) % m;
      r = W'(res);
      n = (res >= half);
      z = (res == 0);
      return {v, n, z, c, r};
   endfunction

   // Issue one op from IDLE, wait for its result, check it, then drain it.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input string tag);
      logic [W+3:0] exp;
      int lat;
      logic busy_ok;
      exp = ref_op(int'(a), int'(b), int'(op));
      check({tag, "_ready"}, 32'(bus.in_ready), 32'(1));
      bus.A = a;
      bus.B = b;
      bus.sel = op;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      bus.sel = 3'($urandom);
      lat = 1;
      busy_ok = 1'b1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         if (bus.in_ready !== 1'b0 || {bus.flags, bus.R} !== prev_rf) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), (op == 3'b111) ? 32'(W + 1) : 32'(1));
      if (op == 3'b111) check({tag, "_busy_hold"}, 32'(busy_ok), 32'(1));
      check({tag, "_R"}, 32'(bus.R), 32'(exp[W-1:0]));
      check({tag, "_flags"}, 32'(bus.flags), 32'(exp[W+3:W]));
      prev_rf = exp;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_idle"}, 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
   endtask

   initial begin : main
      logic [W+3:0] exp;
      logic hold_ok;
      logic [2:0] op;

      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.sel = '0;

      // Reset state.
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));
      check("rst_R", 32'(bus.R), 32'(0));
      check("rst_flags", 32'(bus.flags), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors.
      run_op(8'hFF, 8'h01, 3'b000, "add_ff_01");
      run_op(8'h80, 8'h01, 3'b001, "sub_80_01");
      run_op(8'h01, 8'h02, 3'b001, "sub_01_02");
      run_op(8'h10, 8'h11, 3'b111, "mul_10_11");
      run_op(8'h0F, 8'h0F, 3'b111, "mul_0f_0f");
      run_op(8'h81, 8'h00, 3'b100, "rol_81");
      run_op(8'h01, 8'h00, 3'b101, "ror_01");
      run_op(8'hFF, 8'hFF, 3'b111, "mul_ff_ff");
      run_op(8'h7F, 8'h7F, 3'b000, "add_7f_7f");

      // Backpressure: result held while out_ready is low.
      exp = ref_op(8'h7F, 8'h01, 0);
      bus.A = 8'h7F;
      bus.B = 8'h01;
      bus.sel = 3'b000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_valid", 32'(bus.out_valid), 32'(1));
      check("bp_R", 32'({bus.flags, bus.R}), 32'(exp));
      hold_ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if ({bus.flags, bus.R} !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            hold_ok = 1'b0;
      end
      check("bp_hold", 32'(hold_ok), 32'(1));
      exp = ref_op(8'hF0, 8'h3C, 2);
      bus.A = 8'hF0;
      bus.B = 8'h3C;
      bus.sel = 3'b010;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("bp_and_valid", 32'(bus.out_valid), 32'(1));
      check("bp_and_R", 32'({bus.flags, bus.R}), 32'(exp));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      prev_rf = exp;

      // Back-to-back non-MUL stream at one op per cycle.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 6));
         bus.A = W'($urandom_range(0, 255));
         bus.B = W'($urandom_range(0, 255));
         bus.sel = op;
         bus.in_valid = 1'b1;
         exp_q.push_back(ref_op(int'(bus.A), int'(bus.B), int'(op)));
         @(negedge clk);
         exp = exp_q.pop_front();
         check($sformatf("b2b_%0d", i), 32'({bus.out_valid, bus.flags, bus.R}), 32'({1'b1, exp}));
         prev_rf = exp;
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("b2b_drain", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));

      // Randomized mix including MUL.
      for (int i = 0; i < 24; i++) begin
         run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                3'($urandom_range(0, 7)), $sformatf("rnd_%0d", i));
      end

      // Reset in the middle of a MUL.
      run_op(8'h01, 8'h02, 3'b000, "pre_rst");
      bus.A = 8'h10;
      bus.B = 8'h11;
      bus.sel = 3'b111;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_out_valid", 32'(bus.out_valid), 32'(0));
      check("mrst_R", 32'(bus.R), 32'(0));
      check("mrst_flags", 32'(bus.flags), 32'(0));
      check("mrst_in_ready", 32'(bus.in_ready), 32'(1));
      prev_rf = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hold_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) hold_ok = 1'b0;
      end
      check("mrst_quiet", 32'(hold_ok), 32'(1));
      run_op(8'h0F, 8'h0F, 3'b111, "post_rst_mul");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
